// File: rtl/mux_slice_pkg.sv
// Shared types and default sizing for the keyed slice assembler.
package mux_slice_pkg;

    localparam int NR_SLOT_DEF = 4;
    localparam int SLICE_W_DEF = 2;
    localparam int KEY_LEN_DEF = 2;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/mux_slice_assembler_slot_decoder.sv
// Key-to-slot decoder: turns a slot key into a one-hot write enable.
// It does the reverse of a keyed mux lookup. A key beyond the last slot
// enables nothing and reports out of range.
module slot_decoder
    import mux_slice_pkg::*;
#(
    parameter int NR_SLOT = NR_SLOT_DEF,
    parameter int KEY_LEN = KEY_LEN_DEF
) (
    input  logic [KEY_LEN-1:0] key,
    input  logic               en,
    output logic [NR_SLOT-1:0] we,
    output logic               in_range
);

    assign in_range = (int'(key) < NR_SLOT);

    // One-hot enable, gated by the request and the range check.
    always_comb begin
        we = '0;
        for (int i = 0; i < NR_SLOT; i++) begin
            we[i] = en && in_range && (int'(key) == i);
        end
    end

endmodule

// File: rtl/mux_slice_assembler.sv
// Assembles keyed narrow slices into a full word and presents the word
// over a valid/ready output. The input stalls while a finished word waits.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   COLLECT | accepting slices; word is partial and out_valid is low
//   HOLD    | every slot is written; word is held until out_ready
module mux_slice_assembler
    import mux_slice_pkg::*;
#(
    parameter  int NR_SLOT  = NR_SLOT_DEF,
    parameter  int SLICE_W  = SLICE_W_DEF,
    parameter  int KEY_LEN  = KEY_LEN_DEF,
    localparam int DATA_LEN = NR_SLOT * SLICE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_LEN-1:0]  in_key,
    input  logic [SLICE_W-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic [NR_SLOT-1:0]  slot_mask,
    output logic                dup_err,
    output logic                range_err
);

    state_t                state_q, state_d;
    logic [DATA_LEN-1:0]   data_q;
    logic [NR_SLOT-1:0]    mask_q;
    logic [NR_SLOT-1:0]    slot_we;
    logic                  key_in_range;
    logic                  accept;
    logic                  word_taken;

    // clear wins over everything, so a slice offered alongside it is never accepted.
    assign in_ready   = (state_q == COLLECT);
    assign out_valid  = (state_q == HOLD);
    assign accept     = in_valid && in_ready && !clear;
    assign word_taken = out_valid && out_ready;

    slot_decoder #(
        .NR_SLOT (NR_SLOT),
        .KEY_LEN (KEY_LEN)
    ) u_slot_decoder (
        .key      (in_key),
        .en       (accept),
        .we       (slot_we),
        .in_range (key_in_range)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: move to HOLD on the write that fills the last empty slot.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (&(mask_q | slot_we)) state_d = HOLD;
            HOLD:    if (out_ready)           state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
        if (clear) state_d = COLLECT;
    end

    // Data and mask registers: empty on clear or when the word is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            mask_q <= '0;
        end else if (clear || word_taken) begin
            data_q <= '0;
            mask_q <= '0;
        end else begin
            for (int i = 0; i < NR_SLOT; i++) begin
                if (slot_we[i]) data_q[i*SLICE_W +: SLICE_W] <= in_data;
            end
            mask_q <= mask_q | slot_we;
        end
    end

    // Error pulses, high for the single cycle after the offending accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dup_err   <= 1'b0;
            range_err <= 1'b0;
        end else begin
            dup_err   <= |(slot_we & mask_q);
            range_err <= accept && !key_in_range;
        end
    end

    assign out_data  = data_q;
    assign slot_mask = mask_q;

endmodule

// File: tb/tb_mux_slice_assembler.sv
// Bench for mux_slice_assembler. Directed scenarios are followed by random
// traffic, and every cycle is compared against a slot-array reference model.
module tb_mux_slice_assembler;

    localparam int NS = 4;
    localparam int SW = 2;
    localparam int KL = 2;
    localparam int DL = NS * SW;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [KL-1:0] in_key;
    logic [SW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DL-1:0] out_data;
    logic [NS-1:0] slot_mask;
    logic          dup_err;
    logic          range_err;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: slot contents, which slots are filled, a pending word flag and pulses.
    logic [SW-1:0] m_slot [NS];
    bit            m_wr   [NS];
    bit            m_hold;
    bit            m_dup;
    bit            m_rng;

    always #5 clk = ~clk;

    mux_slice_assembler #(
        .NR_SLOT (NS),
        .SLICE_W (SW),
        .KEY_LEN (KL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .slot_mask (slot_mask),
        .dup_err   (dup_err),
        .range_err (range_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DL-1:0] exp_word();
        int w = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_wr[i]) w += int'(m_slot[i]) * (1 << (SW * i));
        end
        return w[DL-1:0];
    endfunction

    function automatic logic [NS-1:0] exp_mask();
        logic [NS-1:0] m = '0;
        for (int i = 0; i < NS; i++) m[i] = m_wr[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_slot[i] = '0;
            m_wr[i]   = 1'b0;
        end
        m_hold = 1'b0;
        m_dup  = 1'b0;
        m_rng  = 1'b0;
    endtask

    task automatic model_step(input logic c, input logic v, input logic [KL-1:0] k,
                              input logic [SW-1:0] d, input logic ordy);
        int filled;
        m_dup = 1'b0;
        m_rng = 1'b0;
        if (c) begin
            model_reset();
        end else if (m_hold) begin
            if (ordy) model_reset();
        end else if (v) begin
            if (int'(k) >= NS) begin
                m_rng = 1'b1;
            end else begin
                if (m_wr[k]) m_dup = 1'b1;
                m_slot[k] = d;
                m_wr[k]   = 1'b1;
                filled = 0;
                for (int i = 0; i < NS; i++) if (m_wr[i]) filled++;
                if (filled == NS) m_hold = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(!m_hold));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_hold));
        chk({tag, ".out_data"},  32'(out_data),  32'(exp_word()));
        chk({tag, ".slot_mask"}, 32'(slot_mask), 32'(exp_mask()));
        chk({tag, ".dup_err"},   32'(dup_err),   32'(m_dup));
        chk({tag, ".range_err"}, 32'(range_err), 32'(m_rng));
    endtask

    // Drive one cycle of inputs, advance the model, then compare just after the edge.
    task automatic step(input string tag, input logic c, input logic v, input logic [KL-1:0] k,
                        input logic [SW-1:0] d, input logic ordy);
        clear     = c;
        in_valid  = v;
        in_key    = k;
        in_data   = d;
        out_ready = ordy;
        model_step(c, v, k, d, ordy);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic          r_c, r_v, r_o;
        logic [KL-1:0] r_k;
        logic [SW-1:0] r_d;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_key = '0; in_data = '0; out_ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // In-order fill with the consumer ready.
        step("fill0", 1'b0, 1'b1, 2'd0, 2'b01, 1'b1);
        step("fill1", 1'b0, 1'b1, 2'd1, 2'b10, 1'b1);
        step("fill2", 1'b0, 1'b1, 2'd2, 2'b11, 1'b1);
        step("fill3", 1'b0, 1'b1, 2'd3, 2'b00, 1'b1);
        chk("fill.word", 32'(out_data), 32'h39);
        chk("fill.valid", 32'(out_valid), 32'd1);
        step("fill.take", 1'b0, 1'b0, 2'd0, 2'b00, 1'b1);
        chk("fill.after_data", 32'(out_data), 32'h0);
        chk("fill.after_mask", 32'(slot_mask), 32'h0);

        // Out-of-order fill, then hold under backpressure.
        step("ooo0", 1'b0, 1'b1, 2'd3, 2'b11, 1'b0);
        chk("ooo.mask0", 32'(slot_mask), 32'b1000);
        step("ooo1", 1'b0, 1'b1, 2'd0, 2'b00, 1'b0);
        chk("ooo.mask1", 32'(slot_mask), 32'b1001);
        step("ooo2", 1'b0, 1'b1, 2'd2, 2'b01, 1'b0);
        chk("ooo.mask2", 32'(slot_mask), 32'b1101);
        step("ooo3", 1'b0, 1'b1, 2'd1, 2'b10, 1'b0);
        chk("ooo.mask3", 32'(slot_mask), 32'b1111);
        chk("ooo.word", 32'(out_data), 32'hD8);
        for (int i = 0; i < 5; i++) begin
            step("stall", 1'b0, 1'b1, 2'(i), 2'b01, 1'b0);
            chk("stall.word", 32'(out_data), 32'hD8);
            chk("stall.in_ready", 32'(in_ready), 32'd0);
        end
        step("stall.take", 1'b0, 1'b0, 2'd0, 2'b00, 1'b1);
        chk("stall.after_data", 32'(out_data), 32'h0);
        chk("stall.after_mask", 32'(slot_mask), 32'h0);

        // Duplicate write to slot 1.
        step("dup0", 1'b0, 1'b1, 2'd1, 2'b01, 1'b0);
        chk("dup.first_pulse", 32'(dup_err), 32'd0);
        step("dup1", 1'b0, 1'b1, 2'd1, 2'b11, 1'b0);
        chk("dup.pulse", 32'(dup_err), 32'd1);
        chk("dup.slot1", 32'(out_data[3:2]), 32'b11);
        chk("dup.mask", 32'(slot_mask), 32'b0010);
        step("dup.idle", 1'b0, 1'b0, 2'd0, 2'b00, 1'b0);
        chk("dup.pulse_end", 32'(dup_err), 32'd0);

        // clear on a partial word alongside a valid slice.
        step("clr.w0", 1'b0, 1'b1, 2'd0, 2'b10, 1'b0);
        chk("clr.mask_before", 32'(slot_mask), 32'b0011);
        step("clr", 1'b1, 1'b1, 2'd2, 2'b11, 1'b0);
        chk("clr.mask", 32'(slot_mask), 32'h0);
        chk("clr.data", 32'(out_data), 32'h0);
        chk("clr.dup", 32'(dup_err), 32'd0);

        // Async reset while holding a full word, between clock edges.
        step("ar0", 1'b0, 1'b1, 2'd0, 2'b11, 1'b0);
        step("ar1", 1'b0, 1'b1, 2'd1, 2'b11, 1'b0);
        step("ar2", 1'b0, 1'b1, 2'd2, 2'b11, 1'b0);
        step("ar3", 1'b0, 1'b1, 2'd3, 2'b11, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.out_valid", 32'(out_valid), 32'd0);
        chk("arst.in_ready", 32'(in_ready), 32'd1);
        chk("arst.out_data", 32'(out_data), 32'h0);
        chk("arst.slot_mask", 32'(slot_mask), 32'h0);
        model_reset();
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        step("post0", 1'b0, 1'b1, 2'd0, 2'b01, 1'b1);
        step("post1", 1'b0, 1'b1, 2'd1, 2'b10, 1'b1);
        step("post2", 1'b0, 1'b1, 2'd2, 2'b11, 1'b1);
        step("post3", 1'b0, 1'b1, 2'd3, 2'b00, 1'b1);
        chk("post.word", 32'(out_data), 32'h39);
        step("post.take", 1'b0, 1'b0, 2'd0, 2'b00, 1'b1);

        // Random traffic against the model.
        repeat (1500) begin
            r_c = ($urandom_range(15) == 0);
            r_v = ($urandom_range(3) != 0);
            r_k = KL'($urandom_range(NS - 1));
            r_d = SW'($urandom_range((1 << SW) - 1));
            r_o = ($urandom_range(1) != 0);
            step("rnd", r_c, r_v, r_k, r_d, r_o);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
